intr_ctrl: RTL and testbench

- Interrupt controller that sequences the CPU datapath between main-program and interrupt-handler execution.
- Latches edge-triggered requests, arbitrates them by fixed priority, and redirects the PC to a per-source vector.
- Holds the return address for the return-from-interrupt instruction.
- Drives the ALU `interruption` input, which selects the handler flag bank (carry_intr/zero_intr) instead of the main bank (carry/zero); no flag save/restore is needed.

---
 rtl/intr_ctrl.sv | 112 +++++++++++
 tb/tb_intr_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches edge-triggered requests, arbitrates by fixed priority
// (index 0 highest), redirects the PC to a per-source vector and holds the return address.
module intr_ctrl #(
    parameter int                  ID_WIDTH   = 2,
    parameter int                  PC_WIDTH   = 10,
    parameter logic [PC_WIDTH-1:0] VEC_BASE   = 10'h3C0,
    parameter int                  VEC_STRIDE = 4,
    localparam int                 NUM_IRQ    = 2 ** ID_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_din,
    input  logic [PC_WIDTH-1:0] pc_next,
    input  logic                reti,
    output logic                take_intr,
    output logic [PC_WIDTH-1:0] vector,
    output logic [PC_WIDTH-1:0] ret_addr,
    output logic                interruption,
    output logic [ID_WIDTH-1:0] active_id,
    output logic [NUM_IRQ-1:0]  pending,
    output logic [NUM_IRQ-1:0]  mask
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        SERVICE = 2'd2,
        EXIT    = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [NUM_IRQ-1:0]  irq_q_reg;
    logic [NUM_IRQ-1:0]  pending_reg, pending_next;
    logic [NUM_IRQ-1:0]  mask_reg;
    logic [PC_WIDTH-1:0] ret_addr_reg;
    logic [ID_WIDTH-1:0] active_id_reg;
    logic [NUM_IRQ-1:0]  irq_edge;
    logic [NUM_IRQ-1:0]  enter_clr;
    logic [NUM_IRQ-1:0]  req;
    logic [ID_WIDTH-1:0] sel_id;

    // A new edge wins over the ENTER-cycle clear so a re-request is never lost.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            assign irq_edge[gi]     = irq[gi] & ~irq_q_reg[gi];
            assign enter_clr[gi]    = (state_reg == ENTER) && (active_id_reg == ID_WIDTH'(gi));
            assign pending_next[gi] = irq_edge[gi] | (pending_reg[gi] & ~enter_clr[gi]);
        end
    endgenerate

    assign req = pending_reg & mask_reg;

    // Scan from the top down so the lowest requesting index ends up selected.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) sel_id = ID_WIDTH'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req != '0) state_next = ENTER;
            ENTER:   state_next = SERVICE;
            SERVICE: if (reti) state_next = EXIT;
            EXIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        take_intr    = 1'b0;
        interruption = 1'b0;
        case (state_reg)
            ENTER:   take_intr    = 1'b1;
            SERVICE: interruption = 1'b1;
            default: ;
        endcase
    end

    // irq_q starts at all ones so lines already high at reset release are not edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q_reg     <= '1;
            pending_reg   <= '0;
            mask_reg      <= '0;
            ret_addr_reg  <= '0;
            active_id_reg <= '0;
        end else begin
            irq_q_reg   <= irq;
            pending_reg <= pending_next;
            if (mask_we) mask_reg <= mask_din;
            if (state_reg == IDLE && req != '0) active_id_reg <= sel_id;
            if (state_reg == ENTER) ret_addr_reg <= pc_next;
        end
    end

    assign vector    = VEC_BASE + PC_WIDTH'(active_id_reg) * PC_WIDTH'(VEC_STRIDE);
    assign ret_addr  = ret_addr_reg;
    assign active_id = active_id_reg;
    assign pending   = pending_reg;
    assign mask      = mask_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// Testbench for intr_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_din = '0;
    logic [9:0] pc_next = '0;
    logic       reti = 1'b0;
    logic       take_intr;
    logic [9:0] vector;
    logic [9:0] ret_addr;
    logic       interruption;
    logic [1:0] active_id;
    logic [3:0] pending;
    logic [3:0] mask;

    int n_cmp = 0;
    int n_err = 0;

    intr_ctrl dut (
        .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_din(mask_din),
        .pc_next(pc_next), .reti(reti), .take_intr(take_intr), .vector(vector),
        .ret_addr(ret_addr), .interruption(interruption), .active_id(active_id),
        .pending(pending), .mask(mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] irq;
        logic [9:0] pc;
        logic       reti;
        logic       e_take;
        logic       e_intr;
        logic [1:0] e_id;
        logic [3:0] e_pend;
        logic [9:0] e_ret;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic [3:0] ir, input logic [9:0] pc, input logic rt,
                                input logic tk, input logic it, input logic [1:0] id,
                                input logic [3:0] pd, input logic [9:0] ra);
        vec_t v;
        v.irq = ir; v.pc = pc; v.reti = rt; v.e_take = tk; v.e_intr = it;
        v.e_id = id; v.e_pend = pd; v.e_ret = ra;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic [3:0] held_irq);
        reset = 1'b1; irq = held_irq; mask_we = 1'b0; mask_din = '0; pc_next = '0; reti = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: the handler lifecycle is tracked as three activity flags.
    logic [3:0] m_pend, m_msk, m_prev;
    logic [1:0] m_id;
    logic [9:0] m_ret;
    bit m_entering, m_in_handler, m_leaving;

    task automatic model_reset();
        m_pend = '0; m_msk = '0; m_prev = 4'hF; m_id = '0; m_ret = '0;
        m_entering = 0; m_in_handler = 0; m_leaving = 0;
    endtask

    task automatic model_step(input logic [3:0] ir, input logic we, input logic [3:0] md,
                              input logic [9:0] pc, input logic rt);
        logic [3:0] edges, avail;
        bit was_entering, was_in, was_leaving;
        edges = ir & ~m_prev;
        m_prev = ir;
        avail = m_pend & m_msk;
        was_entering = m_entering; was_in = m_in_handler; was_leaving = m_leaving;
        m_entering = 0; m_in_handler = 0; m_leaving = 0;
        if (was_entering) begin
            m_pend[m_id] = 1'b0;
            m_ret = pc;
            m_in_handler = 1;
        end else if (was_in) begin
            if (rt) m_leaving = 1; else m_in_handler = 1;
        end else if (!was_leaving && avail != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (avail[i]) begin m_id = 2'(i); break; end
            end
            m_entering = 1;
            $display("model: ENTER source %0d, vector %h", m_id, 10'h3C0 + 10'(m_id) * 10'd4);
        end
        m_pend = m_pend | edges;
        if (we) m_msk = md;
    endtask

    initial begin
        // Lines high at reset release are not edges.
        do_reset(4'b0001);
        mask_we = 1'b1; mask_din = 4'hF;
        @(negedge clk);
        mask_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("held_irq_no_take", take_intr, 0);
            chk("held_irq_no_pending", pending, 0);
        end
        chk("mask_loaded", mask, 4'hF);
        $display("seq: reset release with irq0 held, no service for 10 cycles");
        irq = '0;

        // Directed table: single request, then simultaneous sources 3 and 1.
        tbl[0]  = mk(4'b0100, 10'h000, 0, 0, 0, 2'd0, 4'b0000, 10'h000);
        tbl[1]  = mk(4'b0000, 10'h000, 0, 0, 0, 2'd0, 4'b0100, 10'h000);
        tbl[2]  = mk(4'b0000, 10'h025, 0, 1, 0, 2'd2, 4'b0100, 10'h000);
        tbl[3]  = mk(4'b0000, 10'h3FF, 0, 0, 1, 2'd2, 4'b0000, 10'h025);
        tbl[4]  = mk(4'b0000, 10'h111, 1, 0, 1, 2'd2, 4'b0000, 10'h025);
        tbl[5]  = mk(4'b0000, 10'h222, 0, 0, 0, 2'd2, 4'b0000, 10'h025);
        tbl[6]  = mk(4'b0000, 10'h000, 1, 0, 0, 2'd2, 4'b0000, 10'h025);
        tbl[7]  = mk(4'b1010, 10'h000, 0, 0, 0, 2'd2, 4'b0000, 10'h025);
        tbl[8]  = mk(4'b0000, 10'h000, 0, 0, 0, 2'd2, 4'b1010, 10'h025);
        tbl[9]  = mk(4'b0000, 10'h100, 0, 1, 0, 2'd1, 4'b1010, 10'h025);
        tbl[10] = mk(4'b0000, 10'h000, 1, 0, 1, 2'd1, 4'b1000, 10'h100);
        tbl[11] = mk(4'b0000, 10'h000, 0, 0, 0, 2'd1, 4'b1000, 10'h100);
        tbl[12] = mk(4'b0000, 10'h000, 0, 0, 0, 2'd1, 4'b1000, 10'h100);
        tbl[13] = mk(4'b0000, 10'h200, 0, 1, 0, 2'd3, 4'b1000, 10'h100);
        tbl[14] = mk(4'b0000, 10'h000, 1, 0, 1, 2'd3, 4'b0000, 10'h200);
        tbl[15] = mk(4'b0000, 10'h000, 0, 0, 0, 2'd3, 4'b0000, 10'h200);
        tbl[16] = mk(4'b0000, 10'h000, 0, 0, 0, 2'd3, 4'b0000, 10'h200);
        for (int r = 0; r < 17; r++) begin
            @(negedge clk);
            chk($sformatf("row%0d_take", r), take_intr, tbl[r].e_take);
            chk($sformatf("row%0d_intr", r), interruption, tbl[r].e_intr);
            chk($sformatf("row%0d_id", r), active_id, tbl[r].e_id);
            chk($sformatf("row%0d_vector", r), vector, 10'h3C0 + 10'(tbl[r].e_id) * 10'd4);
            chk($sformatf("row%0d_pending", r), pending, tbl[r].e_pend);
            chk($sformatf("row%0d_ret", r), ret_addr, tbl[r].e_ret);
            $display("row %0d: irq=%b pc=%h reti=%b take=%b intr=%b id=%0d pend=%b ret=%h",
                     r, tbl[r].irq, tbl[r].pc, tbl[r].reti, take_intr, interruption,
                     active_id, pending, ret_addr);
            irq = tbl[r].irq; pc_next = tbl[r].pc; reti = tbl[r].reti;
        end

        // Masked request waits, then enters two cycles after the mask enables it.
        @(negedge clk);
        irq = '0; reti = 1'b0; mask_we = 1'b1; mask_din = 4'b1011;
        @(negedge clk);
        mask_we = 1'b0; irq = 4'b0100;
        @(negedge clk);
        irq = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("masked_pending", pending, 4'b0100);
            chk("masked_no_take", take_intr, 0);
        end
        mask_we = 1'b1; mask_din = 4'hF;
        @(negedge clk);
        mask_we = 1'b0;
        chk("unmask_not_yet", take_intr, 0);
        @(negedge clk);
        chk("unmask_take", take_intr, 1);
        chk("unmask_id", active_id, 2);
        $display("seq: masked source 2 entered after mask write");
        @(negedge clk);
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        @(negedge clk);

        // New edge on the active source during ENTER stays pending.
        irq = 4'b0001;
        @(negedge clk);
        irq = '0;
        @(negedge clk);
        chk("reedge_enter_take", take_intr, 1);
        chk("reedge_enter_id", active_id, 0);
        irq = 4'b0001;
        @(negedge clk);
        chk("reedge_pending_kept", pending[0], 1);
        chk("reedge_service", interruption, 1);
        irq = '0; reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        chk("reedge_exit_intr", interruption, 0);
        @(negedge clk);
        chk("reedge_idle_take", take_intr, 0);
        @(negedge clk);
        chk("reedge_reenter", take_intr, 1);
        $display("seq: re-request during ENTER serviced again");
        @(negedge clk);
        chk("pre_reset_service", interruption, 1);

        // Asynchronous reset mid-SERVICE takes effect without a clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_intr", interruption, 0);
        chk("rst_take", take_intr, 0);
        chk("rst_pending", pending, 0);
        chk("rst_mask", mask, 0);
        chk("rst_ret", ret_addr, 0);
        chk("rst_id", active_id, 0);
        $display("seq: async reset during SERVICE");

        // Randomized traffic against the reference model.
        do_reset(4'b0000);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] r_irq, r_md;
            logic       r_we, r_rt;
            logic [9:0] r_pc;
            @(negedge clk);
            chk("rnd_take", take_intr, m_entering);
            chk("rnd_intr", interruption, m_in_handler);
            chk("rnd_id", active_id, m_id);
            chk("rnd_vector", vector, (10'h3C0 + 10'(m_id) * 10'd4));
            chk("rnd_ret", ret_addr, m_ret);
            chk("rnd_pending", pending, m_pend);
            chk("rnd_mask", mask, m_msk);
            r_irq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : irq;
            r_we  = ($urandom_range(0, 15) == 0);
            r_md  = 4'($urandom);
            r_pc  = 10'($urandom);
            r_rt  = ($urandom_range(0, 3) == 0);
            irq = r_irq; mask_we = r_we; mask_din = r_md; pc_next = r_pc; reti = r_rt;
            model_step(r_irq, r_we, r_md, r_pc, r_rt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
